// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
//
// Memory-access stage of the 5-stage pipeline. It takes one instruction from
// execute in each accept cycle. For a load or store, it runs a req/ack access
// on the data bus and stalls upstream until the access completes. Load data
// is aligned and extended. The write-back signals are registered and drive
// the register file write port directly.
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-high reset
//   ex_valid            execute stage presents an instruction
//   ex_wreg/ex_waddr    instruction writes register ex_waddr
//   ex_wdata            ALU result for non-memory ops
//   ex_memop            0 none,1 LB,2 LBU,3 LH,4 LHU,5 LW,6 SB,7 SH,8 SW
//   ex_maddr/ex_sdata   byte address and store data of the memory op
//   mem_stall           upstream must hold ex_* (stage is BUSY)
//   dbus_req/we/addr/be/wdata   registered bus request, held until ack
//   dbus_ack/dbus_rdata         access complete / load word (same cycle)
//   wb_we/wb_waddr/wb_wdata     register file write port
//   misalign            one-cycle pulse after accepting a misaligned access
// ---------------------------------------------------------------------------
module mem_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   input  logic        ex_wreg,
   input  logic [4:0]  ex_waddr,
   input  logic [31:0] ex_wdata,
   input  logic [3:0]  ex_memop,
   input  logic [31:0] ex_maddr,
   input  logic [31:0] ex_sdata,
   output logic        mem_stall,
   output logic        dbus_req,
   output logic        dbus_we,
   output logic [31:0] dbus_addr,
   output logic [3:0]  dbus_be,
   output logic [31:0] dbus_wdata,
   input  logic        dbus_ack,
   input  logic [31:0] dbus_rdata,
   output logic        wb_we,
   output logic [4:0]  wb_waddr,
   output logic [31:0] wb_wdata,
   output logic        misalign
);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   localparam logic [3:0] OP_LB  = 4'd1;
   localparam logic [3:0] OP_LBU = 4'd2;
   localparam logic [3:0] OP_LH  = 4'd3;
   localparam logic [3:0] OP_LHU = 4'd4;
   localparam logic [3:0] OP_LW  = 4'd5;
   localparam logic [3:0] OP_SB  = 4'd6;
   localparam logic [3:0] OP_SH  = 4'd7;
   localparam logic [3:0] OP_SW  = 4'd8;

   state_t      state_q, state_d;
   logic [3:0]  op_q, op_d;
   logic [1:0]  lane_q, lane_d;
   logic [4:0]  waddr_q, waddr_d;
   logic        wreg_q, wreg_d;

   logic        req_q, req_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] bwdata_q, bwdata_d;

   logic        wb_we_q, wb_we_d;
   logic [4:0]  wb_waddr_q, wb_waddr_d;
   logic [31:0] wb_wdata_q, wb_wdata_d;
   logic        misalign_q, misalign_d;

   // ---------------- decode of the incoming op ----------------
   logic        is_load, is_store, is_byte, is_half, is_word, is_misal;
   logic [3:0]  acc_be;
   logic [31:0] st_wdata;

   always_comb begin
      is_load  = (ex_memop >= OP_LB) && (ex_memop <= OP_LW);
      is_store = (ex_memop >= OP_SB) && (ex_memop <= OP_SW);
      is_byte  = (ex_memop == OP_LB) || (ex_memop == OP_LBU) || (ex_memop == OP_SB);
      is_half  = (ex_memop == OP_LH) || (ex_memop == OP_LHU) || (ex_memop == OP_SH);
      is_word  = (ex_memop == OP_LW) || (ex_memop == OP_SW);
      is_misal = (is_half && ex_maddr[0]) || (is_word && (ex_maddr[1:0] != 2'b00));

      // Byte enables follow the access size and lane. Loads drive them too,
      // so the bus sees which bytes are wanted.
      acc_be = 4'b1111;
      if (is_byte)
         acc_be = 4'b0001 << ex_maddr[1:0];
      else if (is_half)
         acc_be = ex_maddr[1] ? 4'b1100 : 4'b0011;

      // Store data is replicated across lanes so that the byte enables alone
      // pick the destination bytes.
      st_wdata = ex_sdata;
      if (is_byte)
         st_wdata = {4{ex_sdata[7:0]}};
      else if (is_half)
         st_wdata = {2{ex_sdata[15:0]}};
   end

   // ---------------- load alignment ----------------
   logic [31:0] ld_shift;
   logic [31:0] ld_data;

   always_comb begin
      // Shift the addressed lane down to bit 0. A half-word lane is 0 or 2,
      // so the same shift also serves LH/LHU.
      ld_shift = dbus_rdata >> {lane_q, 3'b000};
      case (op_q)
         OP_LB:   ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
         OP_LBU:  ld_data = {24'd0, ld_shift[7:0]};
         OP_LH:   ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
         OP_LHU:  ld_data = {16'd0, ld_shift[15:0]};
         default: ld_data = dbus_rdata;
      endcase
   end

   // ---------------- next-state / output logic ----------------
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      lane_d     = lane_q;
      waddr_d    = waddr_q;
      wreg_d     = wreg_q;
      req_d      = req_q;
      we_d       = we_q;
      addr_d     = addr_q;
      be_d       = be_q;
      bwdata_d   = bwdata_q;
      wb_we_d    = 1'b0;
      wb_waddr_d = 5'd0;
      wb_wdata_d = 32'd0;
      misalign_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (ex_valid) begin
               if (is_load || is_store) begin
                  if (is_misal) begin
                     misalign_d = 1'b1;
                  end else begin
                     state_d  = BUSY;
                     op_d     = ex_memop;
                     lane_d   = ex_maddr[1:0];
                     waddr_d  = ex_waddr;
                     wreg_d   = ex_wreg;
                     req_d    = 1'b1;
                     we_d     = is_store;
                     addr_d   = {ex_maddr[31:2], 2'b00};
                     be_d     = acc_be;
                     bwdata_d = is_store ? st_wdata : 32'd0;
                  end
               end else begin
                  wb_we_d    = ex_wreg && (ex_waddr != 5'd0);
                  wb_waddr_d = ex_waddr;
                  wb_wdata_d = ex_wdata;
               end
            end
         end
         BUSY: begin
            if (dbus_ack) begin
               state_d  = IDLE;
               req_d    = 1'b0;
               we_d     = 1'b0;
               addr_d   = 32'd0;
               be_d     = 4'd0;
               bwdata_d = 32'd0;
               if (!we_q) begin
                  wb_we_d    = wreg_q && (waddr_q != 5'd0);
                  wb_waddr_d = waddr_q;
                  wb_wdata_d = ld_data;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         op_q       <= 4'd0;
         lane_q     <= 2'd0;
         waddr_q    <= 5'd0;
         wreg_q     <= 1'b0;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= 32'd0;
         be_q       <= 4'd0;
         bwdata_q   <= 32'd0;
         wb_we_q    <= 1'b0;
         wb_waddr_q <= 5'd0;
         wb_wdata_q <= 32'd0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         lane_q     <= lane_d;
         waddr_q    <= waddr_d;
         wreg_q     <= wreg_d;
         req_q      <= req_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         be_q       <= be_d;
         bwdata_q   <= bwdata_d;
         wb_we_q    <= wb_we_d;
         wb_waddr_q <= wb_waddr_d;
         wb_wdata_q <= wb_wdata_d;
         misalign_q <= misalign_d;
      end
   end

   assign mem_stall  = (state_q == BUSY);
   assign dbus_req   = req_q;
   assign dbus_we    = we_q;
   assign dbus_addr  = addr_q;
   assign dbus_be    = be_q;
   assign dbus_wdata = bwdata_q;
   assign wb_we      = wb_we_q;
   assign wb_waddr   = wb_waddr_q;
   assign wb_wdata   = wb_wdata_q;
   assign misalign   = misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage
//
// Directed testbench for mem_stage. Inputs change 1 ns after each rising
// edge, and outputs are sampled at the same point. Expected values are
// worked out by hand from the behaviour of the memory stage.
// ---------------------------------------------------------------------------
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid, ex_wreg;
   logic [4:0]  ex_waddr;
   logic [31:0] ex_wdata;
   logic [3:0]  ex_memop;
   logic [31:0] ex_maddr, ex_sdata;
   logic        mem_stall;
   logic        dbus_req, dbus_we;
   logic [31:0] dbus_addr;
   logic [3:0]  dbus_be;
   logic [31:0] dbus_wdata;
   logic        dbus_ack;
   logic [31:0] dbus_rdata;
   logic        wb_we;
   logic [4:0]  wb_waddr;
   logic [31:0] wb_wdata;
   logic        misalign;

   int checks = 0;
   int errors = 0;

   mem_stage dut (
      .clk        (clk),
      .rst        (rst),
      .ex_valid   (ex_valid),
      .ex_wreg    (ex_wreg),
      .ex_waddr   (ex_waddr),
      .ex_wdata   (ex_wdata),
      .ex_memop   (ex_memop),
      .ex_maddr   (ex_maddr),
      .ex_sdata   (ex_sdata),
      .mem_stall  (mem_stall),
      .dbus_req   (dbus_req),
      .dbus_we    (dbus_we),
      .dbus_addr  (dbus_addr),
      .dbus_be    (dbus_be),
      .dbus_wdata (dbus_wdata),
      .dbus_ack   (dbus_ack),
      .dbus_rdata (dbus_rdata),
      .wb_we      (wb_we),
      .wb_waddr   (wb_waddr),
      .wb_wdata   (wb_wdata),
      .misalign   (misalign)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [3:0] op, input logic wreg, input logic [4:0] wa,
                        input logic [31:0] wd, input logic [31:0] ma, input logic [31:0] sd);
      ex_valid = 1'b1;
      ex_memop = op;
      ex_wreg  = wreg;
      ex_waddr = wa;
      ex_wdata = wd;
      ex_maddr = ma;
      ex_sdata = sd;
   endtask

   task automatic idle_in();
      ex_valid = 1'b0;
      ex_memop = 4'd0;
      ex_wreg  = 1'b0;
      ex_waddr = 5'd0;
      ex_wdata = 32'd0;
      ex_maddr = 32'd0;
      ex_sdata = 32'd0;
   endtask

   initial begin
      rst = 1'b1;
      idle_in();
      dbus_ack   = 1'b0;
      dbus_rdata = 32'd0;

      // ---- reset state ----
      #1;
      step();
      step();
      chk("rst_stall", {31'd0, mem_stall}, 32'd0);
      chk("rst_req",   {31'd0, dbus_req},  32'd0);
      chk("rst_wbwe",  {31'd0, wb_we},     32'd0);
      chk("rst_misal", {31'd0, misalign},  32'd0);
      chk("rst_addr",  dbus_addr,          32'd0);
      rst = 1'b0;
      $display("reset done");

      // ---- non-memory stream ----
      issue(4'd0, 1'b1, 5'd5, 32'h1234, 32'd0, 32'd0);
      step();
      chk("nm1_we",    {31'd0, wb_we},     32'd1);
      chk("nm1_wa",    {27'd0, wb_waddr},  32'd5);
      chk("nm1_wd",    wb_wdata,           32'h1234);
      chk("nm1_stall", {31'd0, mem_stall}, 32'd0);
      issue(4'd0, 1'b1, 5'd6, 32'h5678, 32'd0, 32'd0);
      step();
      chk("nm2_we",    {31'd0, wb_we},     32'd1);
      chk("nm2_wa",    {27'd0, wb_waddr},  32'd6);
      chk("nm2_wd",    wb_wdata,           32'h5678);
      chk("nm2_stall", {31'd0, mem_stall}, 32'd0);
      idle_in();
      step();
      chk("nm_idle_we", {31'd0, wb_we}, 32'd0);
      chk("nm_idle_wd", wb_wdata,       32'd0);
      $display("non-memory stream: (5,0x1234) (6,0x5678)");

      // ---- LB sign extension, ack after 3 request cycles ----
      issue(4'd1, 1'b1, 5'd7, 32'd0, 32'h103, 32'd0);
      step();
      chk("lb_req1",   {31'd0, dbus_req},  32'd1);
      chk("lb_addr",   dbus_addr,          32'h100);
      chk("lb_we",     {31'd0, dbus_we},   32'd0);
      chk("lb_stall1", {31'd0, mem_stall}, 32'd1);
      step();
      chk("lb_stall2", {31'd0, mem_stall}, 32'd1);
      chk("lb_addr2",  dbus_addr,          32'h100);
      step();
      chk("lb_stall3", {31'd0, mem_stall}, 32'd1);
      chk("lb_nowb",   {31'd0, wb_we},     32'd0);
      dbus_ack   = 1'b1;
      dbus_rdata = 32'h80FF_FF7F;
      step();
      chk("lb_wbwe",   {31'd0, wb_we},     32'd1);
      chk("lb_wa",     {27'd0, wb_waddr},  32'd7);
      chk("lb_wd",     wb_wdata,           32'hFFFF_FF80);
      chk("lb_stall0", {31'd0, mem_stall}, 32'd0);
      chk("lb_req0",   {31'd0, dbus_req},  32'd0);
      chk("lb_addr0",  dbus_addr,          32'd0);
      // ack held high into IDLE must be ignored
      idle_in();
      step();
      chk("ackidle_we",  {31'd0, wb_we},     32'd0);
      chk("ackidle_req", {31'd0, dbus_req},  32'd0);
      chk("ackidle_st",  {31'd0, mem_stall}, 32'd0);
      dbus_ack = 1'b0;
      $display("LB 0x103 -> 0x%08h", 32'hFFFF_FF80);

      // ---- LBU, ack in first request cycle ----
      issue(4'd2, 1'b1, 5'd8, 32'd0, 32'h103, 32'd0);
      step();
      chk("lbu_req", {31'd0, dbus_req}, 32'd1);
      dbus_ack = 1'b1;
      step();
      chk("lbu_we", {31'd0, wb_we},    32'd1);
      chk("lbu_wa", {27'd0, wb_waddr}, 32'd8);
      chk("lbu_wd", wb_wdata,          32'h0000_0080);
      idle_in();
      dbus_ack = 1'b0;
      $display("LBU 0x103 -> 0x00000080");

      // ---- LH at lane 2, sign extended ----
      issue(4'd3, 1'b1, 5'd14, 32'd0, 32'h106, 32'd0);
      step();
      chk("lh_addr", dbus_addr, 32'h104);
      dbus_ack   = 1'b1;
      dbus_rdata = 32'h8001_1234;
      step();
      chk("lh_wd", wb_wdata, 32'hFFFF_8001);
      idle_in();
      dbus_ack = 1'b0;
      $display("LH 0x106 -> 0xFFFF8001");

      // ---- SH encoding ----
      issue(4'd7, 1'b1, 5'd9, 32'd0, 32'h202, 32'hAAAA_BEEF);
      step();
      chk("sh_req",   {31'd0, dbus_req}, 32'd1);
      chk("sh_we",    {31'd0, dbus_we},  32'd1);
      chk("sh_be",    {28'd0, dbus_be},  32'hC);
      chk("sh_wdata", dbus_wdata,        32'hBEEF_BEEF);
      chk("sh_addr",  dbus_addr,         32'h200);
      dbus_ack = 1'b1;
      step();
      chk("sh_wbwe",  {31'd0, wb_we},    32'd0);
      chk("sh_req0",  {31'd0, dbus_req}, 32'd0);
      chk("sh_be0",   {28'd0, dbus_be},  32'd0);
      chk("sh_wd0",   dbus_wdata,        32'd0);
      idle_in();
      dbus_ack = 1'b0;
      $display("SH 0x202 be=1100 wdata=0xBEEFBEEF");

      // ---- SB encoding ----
      issue(4'd6, 1'b1, 5'd9, 32'd0, 32'h201, 32'h0000_005A);
      step();
      chk("sb_be",    {28'd0, dbus_be}, 32'h2);
      chk("sb_wdata", dbus_wdata,       32'h5A5A_5A5A);
      chk("sb_we",    {31'd0, dbus_we}, 32'd1);
      dbus_ack = 1'b1;
      step();
      chk("sb_wbwe", {31'd0, wb_we}, 32'd0);
      idle_in();
      dbus_ack = 1'b0;
      $display("SB 0x201 be=0010 wdata=0x5A5A5A5A");

      // ---- misaligned LW, then immediate next instruction ----
      issue(4'd5, 1'b1, 5'd10, 32'd0, 32'h102, 32'd0);
      step();
      chk("mis_pulse", {31'd0, misalign},  32'd1);
      chk("mis_req",   {31'd0, dbus_req},  32'd0);
      chk("mis_wbwe",  {31'd0, wb_we},     32'd0);
      chk("mis_stall", {31'd0, mem_stall}, 32'd0);
      issue(4'd0, 1'b1, 5'd11, 32'hCAFE, 32'd0, 32'd0);
      step();
      chk("mis_once",  {31'd0, misalign}, 32'd0);
      chk("mis_next_we", {31'd0, wb_we},  32'd1);
      chk("mis_next_wa", {27'd0, wb_waddr}, 32'd11);
      idle_in();
      $display("misaligned LW 0x102 -> misalign pulse");

      // ---- reset mid-access ----
      issue(4'd5, 1'b1, 5'd12, 32'd0, 32'h300, 32'd0);
      step();
      chk("rmid_req1", {31'd0, dbus_req}, 32'd1);
      idle_in();
      rst = 1'b1;
      step();
      chk("rmid_req0",   {31'd0, dbus_req},  32'd0);
      chk("rmid_stall0", {31'd0, mem_stall}, 32'd0);
      chk("rmid_wbwe",   {31'd0, wb_we},     32'd0);
      rst        = 1'b0;
      dbus_ack   = 1'b1;
      dbus_rdata = 32'h1111_2222;
      step();
      chk("rmid_late_we",  {31'd0, wb_we},    32'd0);
      chk("rmid_late_req", {31'd0, dbus_req}, 32'd0);
      dbus_ack = 1'b0;
      $display("reset mid-access abandoned");

      // ---- writes to r0 ----
      issue(4'd0, 1'b1, 5'd0, 32'h55, 32'd0, 32'd0);
      step();
      chk("r0_nm_we", {31'd0, wb_we}, 32'd0);
      issue(4'd5, 1'b1, 5'd0, 32'd0, 32'h400, 32'd0);
      step();
      chk("r0_ld_req", {31'd0, dbus_req}, 32'd1);
      dbus_ack   = 1'b1;
      dbus_rdata = 32'h1234_5678;
      step();
      chk("r0_ld_we",    {31'd0, wb_we},     32'd0);
      chk("r0_ld_stall", {31'd0, mem_stall}, 32'd0);
      idle_in();
      dbus_ack = 1'b0;
      $display("r0 writes suppressed");

      // ---- LW aligned, full word ----
      issue(4'd5, 1'b1, 5'd13, 32'd0, 32'h404, 32'd0);
      step();
      chk("lw_addr", dbus_addr,        32'h404);
      chk("lw_be",   {28'd0, dbus_be}, 32'hF);
      dbus_ack   = 1'b1;
      dbus_rdata = 32'hDEAD_BEEF;
      step();
      chk("lw_we", {31'd0, wb_we}, 32'd1);
      chk("lw_wd", wb_wdata,       32'hDEAD_BEEF);
      idle_in();
      dbus_ack = 1'b0;
      $display("LW 0x404 -> 0xDEADBEEF");

      step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
